// File: rtl/borrow_skip_subtractor_seq_pkg.sv
`default_nettype none
// Shared block width and FSM state type for the Adders-Mania subtract unit.
package adders_pkg;
  localparam int BLK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;
endpackage
`default_nettype wire

// File: rtl/borrow_skip_subtractor_seq_block.sv
`default_nettype none
// Combinational BLK-bit borrow-skip subtract block: d = a - b - bin over one slice.
module borrow_skip_block
  import adders_pkg::*;
(
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           bin,
  output logic [BLK-1:0] d,
  output logic           bout,
  output logic           prop
);
  logic [BLK-1:0] p;
  logic [BLK-1:0] g;
  logic [BLK:0]   bc;

  always_comb begin
    p     = ~(a ^ b);
    g     = ~a & b;
    bc    = '0;
    bc[0] = bin;
    d     = '0;
    for (int i = 0; i < BLK; i++) begin
      d[i]    = a[i] ^ b[i] ^ bc[i];
      bc[i+1] = g[i] | (p[i] & bc[i]);
    end
    prop = &p;
    // A fully propagating block hands the incoming borrow straight through.
    bout = prop ? bin : bc[BLK];
  end
endmodule
`default_nettype wire

// File: rtl/borrow_skip_subtractor_seq.sv
`default_nettype none
// Sequential N-bit subtractor: one borrow-skip block per cycle, LSB block first,
// behind a valid/ready handshake on both sides.
module borrow_skip_subtractor_seq
  import adders_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);
  localparam int NBLK = N / BLK;
  localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  sub_state_t     state;
  sub_state_t     state_nx;
  logic [KW-1:0]  k;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic [N-1:0]   diff_r;
  logic           borrow_r;
  logic           bout_r;
  logic           ovf_r;

  logic [BLK-1:0] blk_a;
  logic [BLK-1:0] blk_b;
  logic [BLK-1:0] blk_d;
  logic           blk_bout;
  logic           blk_prop;
  logic           borrow_nx;
  logic           last_blk;

  assign blk_a    = a_r[k*BLK +: BLK];
  assign blk_b    = b_r[k*BLK +: BLK];
  assign last_blk = (k == KW'(NBLK - 1));

  borrow_skip_block u_blk (
    .a    (blk_a),
    .b    (blk_b),
    .bin  (borrow_r),
    .d    (blk_d),
    .bout (blk_bout),
    .prop (blk_prop)
  );

  // Skip select repeated at the register input so the bypass feeds the borrow flop directly.
  assign borrow_nx = blk_prop ? borrow_r : blk_bout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last_blk)  state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      a_r      <= '0;
      b_r      <= '0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            borrow_r <= bin;
            k        <= '0;
          end
        end
        RUN: begin
          diff_r[k*BLK +: BLK] <= blk_d;
          borrow_r             <= borrow_nx;
          k                    <= k + KW'(1);
          if (last_blk) begin
            bout_r <= borrow_nx;
            ovf_r  <= (a_r[N-1] ^ b_r[N-1]) & (blk_d[BLK-1] ^ a_r[N-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_r;
  assign bout      = bout_r;
  assign ovf       = ovf_r;
endmodule
`default_nettype wire

// File: tb/tb_borrow_skip_subtractor_seq.sv
`default_nettype none
// Self-checking bench: randomized operations against an arithmetic reference model.
module tb_borrow_skip_subtractor_seq;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_diff = '0;
  logic         exp_bout = 1'b0;
  logic         exp_ovf = 1'b0;
  bit           exp_armed = 1'b0;
  bit           prop_mode = 1'b0;

  always #5 clk = ~clk;

  borrow_skip_subtractor_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: {ovf, bout, diff} from plain unsigned and signed arithmetic.
  function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic c);
    logic [N:0] wide;
    longint     sx, sy, sd;
    logic       o;
    wide = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, c};
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    sd   = sx - sy - longint'(c);
    o    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {o, wide[N], wide[N-1:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!exp_armed) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid actual=1 required=0");
      end else begin
        check("diff", diff, exp_diff);
        check("bout", bout, exp_bout);
        check("ovf", ovf, exp_ovf);
        check("in_ready_while_done", in_ready, 1'b0);
      end
    end
  end

  always @(negedge clk) begin
    if (prop_mode && rst_n && !in_ready && !out_valid)
      check("block_prop", dut.u_blk.prop, 1'b1);
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", in_ready, 1'b1);
  endtask

  task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic c,
                       input int hold);
    int lat;
    logic [N+1:0] m;
    wait_idle();
    m         = model(x, y, c);
    exp_diff  = m[N-1:0];
    exp_bout  = m[N];
    exp_ovf   = m[N+1];
    exp_armed = 1'b1;
    a = x; b = y; bin = c; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = $urandom_range(0, 1);
    a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 9);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        check("held_out_valid", out_valid, 1'b1);
        check("held_in_ready", in_ready, 1'b0);
        @(negedge clk);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("idle_after_release", in_ready, 1'b1);
    check("no_valid_after_release", out_valid, 1'b0);
    exp_armed = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    check("pin_5_3", model(32'h5, 32'h3, 1'b0), {2'b00, 32'h00000002});
    check("pin_0_1", model(32'h0, 32'h1, 1'b0), {2'b01, 32'hFFFFFFFF});
    check("pin_skip", model(32'h12345678, 32'h12345678, 1'b1), {2'b01, 32'hFFFFFFFF});
    check("pin_ovf", model(32'h80000000, 32'h1, 1'b0), {2'b10, 32'h7FFFFFFF});

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_diff", diff, '0);
    check("rst_bout", bout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(32'h00000005, 32'h00000003, 1'b0, 0);
    check("t1_diff", diff, 32'h00000002);
    do_op(32'h00000000, 32'h00000001, 1'b0, 0);
    check("t2_bout", bout, 1'b1);
    prop_mode = 1'b1;
    do_op(32'h12345678, 32'h12345678, 1'b1, 0);
    prop_mode = 1'b0;
    check("t3_diff", diff, 32'hFFFFFFFF);
    do_op(32'h80000000, 32'h00000001, 1'b0, 0);
    check("t4_ovf", ovf, 1'b1);
    do_op(32'hDEADBEEF, 32'h0BADF00D, 1'b1, 5);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1);
    do_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 2);

    // Abort an operation while block 3 is being processed.
    wait_idle();
    a = 32'hCAFEF00D; b = 32'h12345678; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("k_at_abort", dut.k, 3);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_diff", diff, '0);
    check("abort_bout", bout, 1'b0);
    check("abort_ovf", ovf, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(32'h7, 32'h2, 1'b0, 0);
    check("after_abort_diff", diff, 32'h5);

    for (int i = 0; i < 30; i++) begin
      logic [N-1:0] rx, ry;
      rx = $urandom;
      ry = (i % 5 == 0) ? rx : $urandom;
      do_op(rx, ry, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
